// File: rtl/line_sprite_scheduler_pkg.sv
// Shared constants, sprite codes and slot bundle
// for the per-line sprite scheduler.
package line_sprite_scheduler_pkg;

  localparam int NUM_SPRITES  = 8;
  localparam int SLOTS        = 4;
  localparam int SPR_H        = 16;
  localparam int IDX_W        = $clog2(NUM_SPRITES);
  localparam int ROW_W        = $clog2(SPR_H);
  localparam int CNT_W        = $clog2(SLOTS + 1);
  localparam int SLOT_W       = $clog2(SLOTS);
  localparam int SPR_H_SCALED = SPR_H;
  localparam int SCHED_SLOTS  = SLOTS;
  localparam int RES_V        = 480;

  typedef enum logic [2:0] {
    SPR_PLAYER = 3'd0,
    SPR_INV_A  = 3'd1,
    SPR_INV_B  = 3'd2,
    SPR_INV_C  = 3'd3,
    SPR_SHOT_P = 3'd4,
    SPR_SHOT_I = 3'd5,
    SPR_UFO    = 3'd6,
    SPR_BOOM   = 3'd7
  } spr_type_e;

  typedef struct packed {
    logic [9:0]       x;
    logic [2:0]       typ;
    logic [ROW_W-1:0] row;
  } slot_t;

endpackage

// File: rtl/line_sprite_scheduler_match.sv
// Vertical intersection test of one table entry
// against the line being scheduled.
module sprite_row_match
  import line_sprite_scheduler_pkg::*;
(
  input  logic [9:0]       y_l_i,
  input  logic [9:0]       tbl_y_i,
  input  logic             tbl_active_i,
  output logic             hit_o,
  output logic [ROW_W-1:0] row_o
);

  logic [10:0] diff;

  // 11-bit compare with y_l >= tbl_y so lines never wrap
  assign diff  = {1'b0, y_l_i} - {1'b0, tbl_y_i};
  assign hit_o = tbl_active_i
              && (y_l_i >= tbl_y_i)
              && (diff < 11'(SPR_H));
  assign row_o = diff[ROW_W-1:0];

endmodule

// File: rtl/line_sprite_scheduler.sv
// Hblank sprite table walk; double-buffered
// slot list for the draw datapath.
module line_sprite_scheduler
  import line_sprite_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_start,
  input  logic [9:0]             next_y,
  output logic                   tbl_rd,
  output logic [IDX_W-1:0]       tbl_idx,
  input  logic                   tbl_active,
  input  logic [9:0]             tbl_x,
  input  logic [9:0]             tbl_y,
  input  logic [2:0]             tbl_type,
  output logic [SLOTS*10-1:0]    slot_x,
  output logic [SLOTS*3-1:0]     slot_type,
  output logic [SLOTS*ROW_W-1:0] slot_row,
  output logic [SLOTS-1:0]       slot_valid,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_COMMIT
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [9:0]       y_q, y_d;
  slot_t [SLOTS-1:0] sh_q, sh_d;

  logic [SLOTS*10-1:0]    sx_q, sx_d;
  logic [SLOTS*3-1:0]     st_q, st_d;
  logic [SLOTS*ROW_W-1:0] sr_q, sr_d;
  logic [SLOTS-1:0]       sv_q, sv_d;
  logic                   so_q, so_d;

  logic             hit;
  logic [ROW_W-1:0] row;

  sprite_row_match u_match (
    .y_l_i        (y_q),
    .tbl_y_i      (tbl_y),
    .tbl_active_i (tbl_active),
    .hit_o        (hit),
    .row_o        (row)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    y_d     = y_q;
    sh_d    = sh_q;
    sx_d    = sx_q;
    st_d    = st_q;
    sr_d    = sr_q;
    sv_d    = sv_q;
    so_d    = so_q;
    unique case (state_q)
      S_IDLE: begin
        if (line_start) begin
          y_d     = next_y;
          sh_d    = '0;
          cnt_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (hit) begin
          if (cnt_q < CNT_W'(SLOTS)) begin
            sh_d[cnt_q[SLOT_W-1:0]] = '{
              x:   tbl_x,
              typ: tbl_type,
              row: row
            };
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
          state_d = S_COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_COMMIT: begin
        for (int k = 0; k < SLOTS; k++) begin
          sx_d[k*10 +: 10]       = sh_q[k].x;
          st_d[k*3 +: 3]         = sh_q[k].typ;
          sr_d[k*ROW_W +: ROW_W] = sh_q[k].row;
        end
        sv_d    = SLOTS'((1 << cnt_q) - 1);
        so_d    = ovf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      y_q     <= '0;
      sh_q    <= '0;
      sx_q    <= '0;
      st_q    <= '0;
      sr_q    <= '0;
      sv_q    <= '0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      y_q     <= y_d;
      sh_q    <= sh_d;
      sx_q    <= sx_d;
      st_q    <= st_d;
      sr_q    <= sr_d;
      sv_q    <= sv_d;
      so_q    <= so_d;
    end
  end

  assign tbl_rd     = (state_q == S_READ);
  assign tbl_idx    = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_COMMIT);
  assign slot_x     = sx_q;
  assign slot_type  = st_q;
  assign slot_row   = sr_q;
  assign slot_valid = sv_q;
  assign overflow   = so_q;

endmodule

// File: tb/tb_line_sprite_scheduler.sv
// Directed and randomized checks of the sprite
// scheduler against a table-level reference model.
module tb_line_sprite_scheduler;
  import line_sprite_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_start = 1'b0;
  logic [9:0] next_y = '0;
  logic tbl_rd;
  logic [IDX_W-1:0] tbl_idx;
  logic tbl_active = 1'b0;
  logic [9:0] tbl_x = '0;
  logic [9:0] tbl_y = '0;
  logic [2:0] tbl_type = '0;
  logic [SLOTS*10-1:0] slot_x;
  logic [SLOTS*3-1:0] slot_type;
  logic [SLOTS*ROW_W-1:0] slot_row;
  logic [SLOTS-1:0] slot_valid;
  logic overflow, busy, done;

  always #5 clk = ~clk;

  line_sprite_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .line_start(line_start), .next_y(next_y),
    .tbl_rd(tbl_rd), .tbl_idx(tbl_idx),
    .tbl_active(tbl_active), .tbl_x(tbl_x),
    .tbl_y(tbl_y), .tbl_type(tbl_type),
    .slot_x(slot_x), .slot_type(slot_type),
    .slot_row(slot_row), .slot_valid(slot_valid),
    .overflow(overflow), .busy(busy), .done(done)
  );

  logic       t_act [NUM_SPRITES];
  logic [9:0] t_x   [NUM_SPRITES];
  logic [9:0] t_y   [NUM_SPRITES];
  logic [2:0] t_ty  [NUM_SPRITES];

  // table memory with one-cycle read latency
  always @(posedge clk) begin
    if (tbl_rd) begin
      tbl_active <= t_act[tbl_idx];
      tbl_x      <= t_x[tbl_idx];
      tbl_y      <= t_y[tbl_idx];
      tbl_type   <= t_ty[tbl_idx];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NUM_SPRITES; i++) begin
      t_act[i] = 1'b0; t_x[i] = '0; t_y[i] = '0; t_ty[i] = '0;
    end
  endtask

  task automatic set_ent(input int i, input logic a, input int x,
                         input int y, input int ty);
    t_act[i] = a; t_x[i] = 10'(x); t_y[i] = 10'(y); t_ty[i] = 3'(ty);
  endtask

  // hits are every active entry whose rows cover line y; first SLOTS kept
  task automatic check_line(input string tag, input int y);
    int hits[$];
    logic [SLOTS*10-1:0] ex = '0;
    logic [SLOTS*3-1:0] et = '0;
    logic [SLOTS*ROW_W-1:0] er = '0;
    logic [SLOTS-1:0] ev = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      if (t_act[i] && y >= int'(t_y[i]) && y - int'(t_y[i]) < SPR_H)
        hits.push_back(i);
    for (int k = 0; k < SLOTS && k < hits.size(); k++) begin
      ex[k*10 +: 10] = t_x[hits[k]];
      et[k*3 +: 3] = t_ty[hits[k]];
      er[k*ROW_W +: ROW_W] = ROW_W'(y - int'(t_y[hits[k]]));
      ev[k] = 1'b1;
    end
    chk({tag, ".x"}, 64'(slot_x), 64'(ex));
    chk({tag, ".type"}, 64'(slot_type), 64'(et));
    chk({tag, ".row"}, 64'(slot_row), 64'(er));
    chk({tag, ".valid"}, 64'(slot_valid), 64'(ev));
    chk({tag, ".ovf"}, 64'(overflow), 64'(hits.size() > SLOTS));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  // ign_at: cycle at which a spurious one-cycle line_start is injected
  task automatic run_line(input string tag, input int y, input int ign_at);
    int lat = -1;
    int ndone = 0;
    logic stable = 1'b1;
    logic [SLOTS*10-1:0] sx0 = slot_x;
    logic [SLOTS-1:0] sv0 = slot_valid;
    logic [SLOTS*ROW_W-1:0] sr0 = slot_row;
    @(negedge clk);
    line_start = 1'b1;
    next_y = 10'(y);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      line_start = (c == ign_at);
      next_y = 10'($urandom);
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (lat < 0 && (slot_x !== sx0 || slot_valid !== sv0 ||
                      slot_row !== sr0))
        stable = 1'b0;
    end
    line_start = 1'b0;
    chk({tag, ".lat"}, 64'(lat), 64'(2 * NUM_SPRITES + 1));
    chk({tag, ".ndone"}, 64'(ndone), 64'd1);
    chk({tag, ".stable"}, 64'(stable), 64'd1);
    check_line(tag, y);
  endtask

  initial begin
    clear_table();
    #23;
    chk("rst.valid", 64'(slot_valid), 64'd0);
    chk("rst.x", 64'(slot_x), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.rd", 64'(tbl_rd), 64'd0);
    chk("rst.idx", 64'(tbl_idx), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_ent(2, 1, 100, 200, 1);
    run_line("single", 205, -1);
    chk("single.slot0", 64'(slot_x[9:0]), 64'd100);
    chk("single.row0", 64'(slot_row[ROW_W-1:0]), 64'd5);

    @(negedge clk);
    line_start = 1'b1; next_y = 10'd205;
    @(negedge clk);
    line_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(slot_valid), 64'd0);
    chk("midrst.x", 64'(slot_x), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.rd", 64'(tbl_rd), 64'd0);
    chk("midrst.idx", 64'(tbl_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_line("postrst", 205, -1);

    clear_table();
    set_ent(3, 1, 321, 200, 6);
    run_line("b199", 199, -1);
    run_line("b200", 200, -1);
    chk("b200.row", 64'(slot_row[ROW_W-1:0]), 64'd0);
    run_line("b215", 215, -1);
    chk("b215.row", 64'(slot_row[ROW_W-1:0]), 64'd15);
    run_line("b216", 216, -1);
    chk("b216.valid", 64'(slot_valid), 64'd0);
    set_ent(3, 1, 321, 470, 6);
    run_line("nowrap", 0, -1);
    chk("nowrap.valid", 64'(slot_valid), 64'd0);

    clear_table();
    for (int i = 0; i < 6; i++) set_ent(i, 1, 10 + 20 * i, 50, i);
    run_line("ovf", 50, -1);
    chk("ovf.valid", 64'(slot_valid), 64'hf);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.type3", 64'(slot_type[11:9]), 64'd3);

    clear_table();
    for (int i = 0; i < 4; i++) set_ent(i + 4, 1, 7 * i, 300, i);
    run_line("exact4", 303, -1);
    chk("exact4.ovf", 64'(overflow), 64'd0);

    clear_table();
    set_ent(1, 1, 44, 90, 2);
    run_line("busy_ign", 95, 4);
    run_line("commit_ign", 97, 17);

    clear_table();
    set_ent(0, 0, 500, 120, 5);
    set_ent(1, 1, 77, 118, 4);
    run_line("inact", 125, -1);
    chk("inact.valid", 64'(slot_valid), 64'd1);
    chk("inact.x0", 64'(slot_x[9:0]), 64'd77);

    for (int n = 0; n < 25; n++) begin
      int ny;
      ny = $urandom_range(0, RES_V - 1);
      for (int i = 0; i < NUM_SPRITES; i++)
        set_ent(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 639),
                (ny + RES_V - $urandom_range(0, 2 * SPR_H)) % RES_V,
                $urandom_range(0, 7));
      run_line($sformatf("rnd%0d", n), ny, (n % 3 == 0) ? 6 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
